// File: rtl/lamp_fpu_addsub_arb_pkg.sv
// rtl/lamp_fpu_addsub_arb_pkg.sv - shared types for the bfloat16 add/sub arbiter
package lamp_fpu_addsub_arb_pkg;

    localparam int LAMP_ADDSUB_ARB_MAXREQ = 8;

    typedef logic [15:0] bf16_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } addsub_tag_t;

endpackage

// File: rtl/lamp_fpu_rr_arb.sv
// rtl/lamp_fpu_rr_arb.sv - combinational round-robin grant with registered search pointer
module lamp_fpu_rr_arb #(
    parameter int NUM_REQ = 2,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     gnt_id_o,
    output logic               gnt_valid_o
);

    logic [IDW-1:0] ptr_q;
    logic           found;

    // (base + k) mod NUM_REQ without a divider; k < NUM_REQ keeps one subtract enough
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        logic [IDW:0] s;
        s = {1'b0, base} + (IDW+1)'(k);
        if (s >= (IDW+1)'(NUM_REQ)) begin
            s = s - (IDW+1)'(NUM_REQ);
        end
        return s[IDW-1:0];
    endfunction

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[rr_idx(ptr_q, k)]) begin
                found                     = 1'b1;
                gnt_id_o                  = rr_idx(ptr_q, k);
                gnt_o[rr_idx(ptr_q, k)]   = 1'b1;
            end
        end
    end

    assign gnt_valid_o = found;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= rr_idx(gnt_id_o, 1);
        end
    end

endmodule

// File: rtl/lamp_fpu_addsub_arb.sv
// rtl/lamp_fpu_addsub_arb.sv - shares one pipelined bfloat16 add/sub unit among requesters
module lamp_fpu_addsub_arb
    import lamp_fpu_addsub_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LAT     = 2,
    parameter int MAX_OUT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ-1:0]       req_sub_i,
    input  logic [NUM_REQ-1:0][15:0] req_op1_i,
    input  logic [NUM_REQ-1:0][15:0] req_op2_i,
    output logic                     do_o,
    output logic                     sub_o,
    output bf16_t                    op1_o,
    output bf16_t                    op2_o,
    input  logic                     pipe_valid_i,
    input  bf16_t                    pipe_res_i,
    input  logic                     pipe_ovf_i,
    input  logic                     pipe_unf_i,
    output logic [NUM_REQ-1:0]       resp_valid_o,
    output bf16_t                    resp_res_o,
    output logic                     resp_ovf_o,
    output logic                     resp_unf_o,
    output logic                     err_o
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_OUT + 1);

    logic [NUM_REQ-1:0] elig;
    logic [IDW-1:0]     gnt_id;
    logic               accept;

    logic [CW-1:0]      cnt_q [NUM_REQ];
    logic [CW-1:0]      cnt_d [NUM_REQ];

    logic               do_q, sub_q;
    bf16_t              op1_q, op2_q;
    logic [IDW-1:0]     id_q;

    addsub_tag_t        tag_q [LAT];
    addsub_tag_t        tail;
    logic               hit;

    logic [NUM_REQ-1:0] resp_valid_q;
    bf16_t              resp_res_q;
    logic               resp_ovf_q, resp_unf_q;
    logic               err_q;

    // credit masking happens before the arbiter so a full requester is skipped, not stalled on
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid_i[i] && (cnt_q[i] < CW'(MAX_OUT));
        end
    end

    lamp_fpu_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (elig),
        .gnt_o       (req_ready_o),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (accept)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            do_q  <= 1'b0;
            sub_q <= 1'b0;
            op1_q <= '0;
            op2_q <= '0;
            id_q  <= '0;
        end else begin
            do_q <= accept;
            if (accept) begin
                sub_q <= req_sub_i[gnt_id];
                op1_q <= req_op1_i[gnt_id];
                op2_q <= req_op2_i[gnt_id];
                id_q  <= gnt_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= {do_q, 3'(id_q)};
            for (int k = 1; k < LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign tail = tag_q[LAT-1];
    assign hit  = tail.valid && pipe_valid_i;

    // a lost result still returns its credit so the requester cannot deadlock
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            case ({accept && (gnt_id == IDW'(i)), tail.valid && (tail.id == 3'(i))})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            resp_res_q   <= '0;
            resp_ovf_q   <= 1'b0;
            resp_unf_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                resp_valid_q[i] <= hit && (tail.id == 3'(i));
            end
            if (hit) begin
                resp_res_q <= pipe_res_i;
                resp_ovf_q <= pipe_ovf_i;
                resp_unf_q <= pipe_unf_i;
            end
            if (pipe_valid_i != tail.valid) begin
                err_q <= 1'b1;
            end
        end
    end

    assign do_o         = do_q;
    assign sub_o        = sub_q;
    assign op1_o        = op1_q;
    assign op2_o        = op2_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_res_o   = resp_res_q;
    assign resp_ovf_o   = resp_ovf_q;
    assign resp_unf_o   = resp_unf_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_lamp_fpu_addsub_arb.sv
// tb/tb_lamp_fpu_addsub_arb.sv - scoreboard bench for the shared add/sub arbiter
module tb_lamp_fpu_addsub_arb;
    import lamp_fpu_addsub_arb_pkg::*;

    localparam int NR  = 2;
    localparam int LAT = 2;
    localparam int MO  = 2;

    typedef struct packed {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] res;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NR-1:0]       req_valid_i = '0;
    logic [NR-1:0]       req_ready_o;
    logic [NR-1:0]       req_sub_i = '0;
    logic [NR-1:0][15:0] req_op1_i = '0;
    logic [NR-1:0][15:0] req_op2_i = '0;
    logic                do_o, sub_o;
    logic [15:0]         op1_o, op2_o;
    logic                pipe_valid_i, pipe_ovf_i, pipe_unf_i;
    logic [15:0]         pipe_res_i;
    logic [NR-1:0]       resp_valid_o;
    logic [15:0]         resp_res_o;
    logic                resp_ovf_o, resp_unf_o, err_o;

    logic                inj = 1'b0;
    logic                st_v [LAT] = '{default: 1'b0};
    op_t                 st_op [LAT] = '{default: '0};

    op_t  opq [NR][$];
    exp_t sb[$];
    int   lat_q[$];
    int   acc_log[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   resp_seen = 0;

    always #5 clk = ~clk;

    lamp_fpu_addsub_arb #(.NUM_REQ(NR), .LAT(LAT), .MAX_OUT(MO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_sub_i    (req_sub_i),
        .req_op1_i    (req_op1_i),
        .req_op2_i    (req_op2_i),
        .do_o         (do_o),
        .sub_o        (sub_o),
        .op1_o        (op1_o),
        .op2_o        (op2_o),
        .pipe_valid_i (pipe_valid_i),
        .pipe_res_i   (pipe_res_i),
        .pipe_ovf_i   (pipe_ovf_i),
        .pipe_unf_i   (pipe_unf_i),
        .resp_valid_o (resp_valid_o),
        .resp_res_o   (resp_res_o),
        .resp_ovf_o   (resp_ovf_o),
        .resp_unf_o   (resp_unf_o),
        .err_o        (err_o)
    );

    // bfloat16 reference through double precision; normal operands only
    function automatic real bf2r(input logic [15:0] x);
        logic [10:0] e;
        e = (x[14:7] == 8'd0) ? 11'd0 : 11'(x[14:7]) + 11'd896;
        return $bitstoreal({x[15], e, x[6:0], 45'd0});
    endfunction

    function automatic logic [17:0] fpu_model(input op_t o);
        real         r;
        logic [63:0] d;
        int          e8;
        r = o.sub ? bf2r(o.a) - bf2r(o.b) : bf2r(o.a) + bf2r(o.b);
        if (r == 0.0) return 18'd0;
        d  = $realtobits(r);
        e8 = int'(d[62:52]) - 896;
        if (e8 >= 255) return {1'b1, 1'b0, d[63], 8'hFF, 7'h00};
        if (e8 <= 0)   return {1'b0, 1'b1, d[63], 15'h0000};
        return {2'b00, d[63], e8[7:0], d[51:45]};
    endfunction

    // shared add/sub unit stub with fixed latency LAT
    always @(posedge clk) begin
        st_v[0]  <= do_o;
        st_op[0] <= {sub_o, op1_o, op2_o};
        for (int k = 1; k < LAT; k++) begin
            st_v[k]  <= st_v[k-1];
            st_op[k] <= st_op[k-1];
        end
    end

    assign pipe_valid_i = st_v[LAT-1] | inj;
    assign {pipe_ovf_i, pipe_unf_i, pipe_res_i} = fpu_model(st_op[LAT-1]);

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t          e;
        logic [NR-1:0] oh;
        if (resp_valid_o !== '0) begin
            resp_seen++;
            if (sb.size() == 0) begin
                chk("resp_unexpected", 32'(resp_valid_o), 32'd0);
            end else begin
                e  = sb.pop_front();
                oh = NR'(1) << e.id;
                chk("resp_onehot", 32'(resp_valid_o), 32'(oh));
                chk("resp_res", 32'(resp_res_o), 32'(e.res));
                chk("resp_flags", 32'({resp_ovf_o, resp_unf_o}), 32'({e.ovf, e.unf}));
                if (lat_q.size() > 0) chk("resp_latency", 32'(cyc - lat_q.pop_front()), 32'd4);
                else chk("resp_latency_missing", 32'd1, 32'd0);
            end
        end
    end

    task automatic drive(input int budget);
        bit  have_prev;
        op_t prev;
        int  n;
        have_prev = 1'b0;
        prev      = '0;
        n         = 0;
        while ((opq[0].size() > 0 || opq[1].size() > 0 || have_prev) && n < budget) begin
            @(negedge clk);
            n++;
            chk("do_o", 32'(do_o), 32'(have_prev));
            if (have_prev) begin
                chk("sub_o", 32'(sub_o), 32'(prev.sub));
                chk("op1_o", 32'(op1_o), 32'(prev.a));
                chk("op2_o", 32'(op2_o), 32'(prev.b));
            end
            have_prev = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (opq[i].size() > 0) begin
                    req_valid_i[i] = 1'b1;
                    req_sub_i[i]   = opq[i][0].sub;
                    req_op1_i[i]   = opq[i][0].a;
                    req_op2_i[i]   = opq[i][0].b;
                end else begin
                    req_valid_i[i] = 1'b0;
                end
            end
            #1;
            chk("ready_legal", 32'({$onehot0(req_ready_o), (req_ready_o & ~req_valid_i) == '0}), 32'd3);
            for (int i = 0; i < NR; i++) begin
                if (req_valid_i[i] && req_ready_o[i]) begin
                    prev      = opq[i].pop_front();
                    have_prev = 1'b1;
                    lat_q.push_back(cyc);
                    acc_log.push_back(cyc);
                end
            end
        end
        if (opq[0].size() > 0 || opq[1].size() > 0 || have_prev) begin
            chk("drive_timeout", 32'd1, 32'd0);
            opq[0].delete();
            opq[1].delete();
        end
        req_valid_i = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int rs;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_do", 32'(do_o), 32'd0);
        chk("rst_ops", 32'({sub_o, op1_o, op2_o}), 32'd0);
        chk("rst_resp", 32'({resp_valid_o, resp_res_o, resp_ovf_o, resp_unf_o}), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        req_valid_i = 2'b11;
        #1 chk("rst_ready_both", 32'(req_ready_o), 32'b01);
        req_valid_i = 2'b10;
        #1 chk("rst_ready_r1", 32'(req_ready_o), 32'b10);
        req_valid_i = 2'b00;
        #1 chk("rst_ready_none", 32'(req_ready_o), 32'b00);

        opq[0].push_back('{1'b0, 16'h3F80, 16'h4000});
        sb.push_back('{3'd0, 16'h4040, 1'b0, 1'b0});
        drive(20);
        drain();

        do_reset();
        opq[0].push_back('{1'b0, 16'h4000, 16'h4000});
        opq[1].push_back('{1'b1, 16'h4080, 16'h3F80});
        opq[0].push_back('{1'b0, 16'h7F00, 16'h7F00});
        opq[1].push_back('{1'b1, 16'h0100, 16'h00FF});
        opq[0].push_back('{1'b0, 16'h4100, 16'h3F80});
        opq[1].push_back('{1'b1, 16'h40A0, 16'h3F80});
        sb.push_back('{3'd0, 16'h4080, 1'b0, 1'b0});
        sb.push_back('{3'd1, 16'h4040, 1'b0, 1'b0});
        sb.push_back('{3'd0, 16'h7F80, 1'b1, 1'b0});
        sb.push_back('{3'd1, 16'h0000, 1'b0, 1'b1});
        sb.push_back('{3'd0, 16'h4110, 1'b0, 1'b0});
        sb.push_back('{3'd1, 16'h4080, 1'b0, 1'b0});
        drive(40);
        drain();

        do_reset();
        acc_log.delete();
        opq[1].push_back('{1'b0, 16'h3F80, 16'h3F80});
        opq[1].push_back('{1'b0, 16'h4000, 16'h3F80});
        opq[1].push_back('{1'b0, 16'h4040, 16'h3F80});
        opq[1].push_back('{1'b0, 16'h4080, 16'h4080});
        sb.push_back('{3'd1, 16'h4000, 1'b0, 1'b0});
        sb.push_back('{3'd1, 16'h4040, 1'b0, 1'b0});
        sb.push_back('{3'd1, 16'h4080, 1'b0, 1'b0});
        sb.push_back('{3'd1, 16'h4100, 1'b0, 1'b0});
        drive(40);
        chk("credit_accepts", 32'(acc_log.size()), 32'd4);
        if (acc_log.size() == 4) begin
            chk("credit_gap0", 32'(acc_log[1] - acc_log[0]), 32'd1);
            chk("credit_gap1", 32'(acc_log[2] - acc_log[1]), 32'd3);
            chk("credit_gap2", 32'(acc_log[3] - acc_log[2]), 32'd1);
        end
        drain();

        do_reset();
        opq[1].push_back('{1'b1, 16'h4040, 16'h3F80});
        sb.push_back('{3'd1, 16'h4000, 1'b0, 1'b0});
        drive(20);
        drain();
        chk("sub_err", 32'(err_o), 32'd0);

        do_reset();
        rs = resp_seen;
        opq[0].push_back('{1'b0, 16'h3F80, 16'h3F80});
        opq[0].push_back('{1'b0, 16'h4000, 16'h4000});
        drive(20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat_q.delete();
        chk("midrst_do", 32'(do_o), 32'd0);
        chk("midrst_op1", 32'(op1_o), 32'd0);
        chk("midrst_err_clear", 32'(err_o), 32'd0);
        repeat (4) @(negedge clk);
        chk("midrst_err_late", 32'(err_o), 32'd1);
        chk("midrst_no_resp", 32'(resp_seen - rs), 32'd0);

        do_reset();
        rs = resp_seen;
        chk("spur_err_clear", 32'(err_o), 32'd0);
        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("spur_err_set", 32'(err_o), 32'd1);
        repeat (3) @(negedge clk);
        chk("spur_err_held", 32'(err_o), 32'd1);
        chk("spur_no_resp", 32'(resp_seen - rs), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
